// File: rtl/led_pattern_seq_if.sv
// Control/status bundle of the LED pattern sequencer.
// The controller side drives pattern writes and start/stop commands;
// the sequencer side returns the LED drive and run status.
interface led_pattern_seq_if #(
    parameter int NUM_CH  = 2,
    parameter int PAT_LEN = 32
);
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int STW = $clog2(PAT_LEN);

    logic               PAT_WE;
    logic [CHW-1:0]     PAT_CH;
    logic [PAT_LEN-1:0] PAT_DATA;
    logic               START;
    logic               ONESHOT;
    logic               STOP;
    logic [NUM_CH-1:0]  LED;
    logic               BUSY;
    logic               DONE;
    logic [STW-1:0]     STEP;

    modport master (
        output PAT_WE, PAT_CH, PAT_DATA, START, ONESHOT, STOP,
        input  LED, BUSY, DONE, STEP
    );

    modport slave (
        input  PAT_WE, PAT_CH, PAT_DATA, START, ONESHOT, STOP,
        output LED, BUSY, DONE, STEP
    );
endinterface

// File: rtl/led_pattern_seq.sv
// Multi-channel LED pattern sequencer.
// Every channel plays its own PAT_LEN-bit pattern, one bit per step, with
// all channels sharing a single step index advanced by a fixed prescaler.
// Supports looping and one-shot playback; all outputs are registered.
module led_pattern_seq #(
    parameter int NUM_CH   = 2,
    parameter int PAT_LEN  = 32,
    parameter int PRESCALE = 2097152
) (
    input logic              CLK,
    input logic              RESET_N,
    led_pattern_seq_if.slave bus
);
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int STW = $clog2(PAT_LEN);
    localparam int PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [PSW-1:0] PS_LAST   = PSW'(PRESCALE - 1);
    localparam logic [STW-1:0] STEP_LAST = STW'(PAT_LEN - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_q,   state_d;
    logic [STW-1:0]     step_q,    step_d;
    logic [PSW-1:0]     presc_q,   presc_d;
    logic               oneshot_q, oneshot_d;
    logic [PAT_LEN-1:0] pat_q [NUM_CH];
    logic [PAT_LEN-1:0] pat_d [NUM_CH];
    logic [NUM_CH-1:0]  led_q,     led_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;

    // Next-state: pattern store, sequencer state, prescaler and registered outputs
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        state_d   = state_q;
        step_d    = step_q;
        presc_d   = presc_q;
        oneshot_d = oneshot_q;
        done_d    = 1'b0;
        pat_d     = pat_q;

        // Writes to a channel that does not exist match no entry and are dropped.
        for (int c = 0; c < NUM_CH; c++) begin
            if (bus.PAT_WE && (bus.PAT_CH == CHW'(c))) begin
                pat_d[c] = bus.PAT_DATA;
            end
        end

        // Natural advance: the prescaler wraps at PRESCALE-1 and moves the step on.
        if (state_q == ST_RUN) begin
            if (presc_q == PS_LAST) begin
                presc_d = '0;
                if (step_q == STEP_LAST) begin
                    step_d = '0;
                    if (oneshot_q) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    step_d = step_q + STW'(1);
                end
            end else begin
                presc_d = presc_q + PSW'(1);
            end
        end

        // Commands override the natural advance; STOP outranks START while running.
        if (bus.STOP && (state_q == ST_RUN)) begin
            state_d = ST_IDLE;
            step_d  = '0;
            presc_d = '0;
            done_d  = 1'b0;
        end else if (bus.START) begin
            state_d   = ST_RUN;
            step_d    = '0;
            presc_d   = '0;
            oneshot_d = bus.ONESHOT;
            done_d    = 1'b0;
        end

        // Outputs are computed from next state and next patterns so that a
        // pattern write or a START is visible on LED the following cycle.
        busy_d = (state_d == ST_RUN);
        for (int c = 0; c < NUM_CH; c++) begin
            led_d[c] = (state_d == ST_RUN) ? pat_d[c][step_d] : 1'b0;
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            // NOTE: the pattern store is reset too, so LEDs stay dark until patterns are loaded.
            state_q   <= ST_IDLE;
            step_q    <= '0;
            presc_q   <= '0;
            oneshot_q <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                pat_q[c] <= '0;
            end
            led_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            state_q   <= state_d;
            step_q    <= step_d;
            presc_q   <= presc_d;
            oneshot_q <= oneshot_d;
            pat_q     <= pat_d;
            led_q     <= led_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.LED  = led_q;
    assign bus.BUSY = busy_q;
    assign bus.DONE = done_q;
    assign bus.STEP = step_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Directed bench for led_pattern_seq.
// dut_a: NUM_CH=2, PAT_LEN=4, PRESCALE=3.
// dut_b: NUM_CH=1, PAT_LEN=3, PRESCALE=1 (bad-channel write, single-cycle steps).
// Expected {LED, BUSY, DONE, STEP} per cycle are queued as stimulus is driven
// and popped/compared one cycle later, #1 after the rising edge.
module tb_led_pattern_seq;

    logic clk;
    logic rst_n;

    led_pattern_seq_if #(.NUM_CH(2), .PAT_LEN(4)) ifa ();
    led_pattern_seq_if #(.NUM_CH(1), .PAT_LEN(3)) ifb ();

    led_pattern_seq #(.NUM_CH(2), .PAT_LEN(4), .PRESCALE(3)) dut_a (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (ifa)
    );

    led_pattern_seq #(.NUM_CH(1), .PAT_LEN(3), .PRESCALE(1)) dut_b (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (ifb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string      tag;
        int         dut;
        logic [5:0] exp;   // {led[1:0], busy, done, step[1:0]}
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Patterns currently held by the bench's view of dut_a / dut_b
    logic [3:0] p0, p1;
    logic [2:0] q0;

    function automatic logic [1:0] led_a(int s);
        return {p1[s], p0[s]};
    endfunction

    task automatic push_a(string tag, logic [1:0] led, logic busy, logic done, logic [1:0] step);
        exp_t e;
        e.tag = tag;
        e.dut = 0;
        e.exp = {led, busy, done, step};
        sb.push_back(e);
    endtask

    task automatic push_b(string tag, logic led, logic busy, logic done, logic [1:0] step);
        exp_t e;
        e.tag = tag;
        e.dut = 1;
        e.exp = {1'b0, led, busy, done, step};
        sb.push_back(e);
    endtask

    // One clock: compare the oldest expectation, then drop all pulse inputs.
    task automatic cyc();
        exp_t       e;
        logic [5:0] obs;
        @(posedge clk);
        #1;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=none expected=entry");
        end else begin
            e = sb.pop_front();
            if (e.dut == 0) obs = {ifa.LED, ifa.BUSY, ifa.DONE, ifa.STEP};
            else            obs = {1'b0, ifb.LED, ifb.BUSY, ifb.DONE, ifb.STEP};
            assert (obs === e.exp)
            else begin
                errors++;
                $error("FAIL %s observed={led,busy,done,step}=%b expected=%b", e.tag, obs, e.exp);
            end
        end
        ifa.START  = 1'b0;
        ifa.STOP   = 1'b0;
        ifa.PAT_WE = 1'b0;
        ifb.START  = 1'b0;
        ifb.STOP   = 1'b0;
        ifb.PAT_WE = 1'b0;
    endtask

    // Cycles first..last after a START on dut_a: step = cycle/3, wrapping at 4.
    task automatic run_a(string tag, int first, int last);
        logic [1:0] s;
        for (int i = first; i <= last; i++) begin
            s = 2'((i / 3) % 4);
            push_a($sformatf("%s_c%0d", tag, i), led_a(int'(s)), 1'b1, 1'b0, s);
            cyc();
        end
    endtask

    task automatic idle_a(string tag);
        push_a(tag, 2'b00, 1'b0, 1'b0, 2'd0);
        cyc();
    endtask

    initial begin
        rst_n        = 1'b0;
        ifa.PAT_WE   = 1'b0;
        ifa.PAT_CH   = '0;
        ifa.PAT_DATA = '0;
        ifa.START    = 1'b0;
        ifa.ONESHOT  = 1'b0;
        ifa.STOP     = 1'b0;
        ifb.PAT_WE   = 1'b0;
        ifb.PAT_CH   = '0;
        ifb.PAT_DATA = '0;
        ifb.START    = 1'b0;
        ifb.ONESHOT  = 1'b0;
        ifb.STOP     = 1'b0;
        p0 = 4'b0000;
        p1 = 4'b0000;
        q0 = 3'b000;

        // Reset held two cycles with START asserted
        ifa.START = 1'b1; ifb.START = 1'b1;
        idle_a("reset_c0");
        ifa.START = 1'b1; ifb.START = 1'b1;
        idle_a("reset_c1");
        rst_n = 1'b1;

        // START with all-zero patterns: running but dark
        ifa.START = 1'b1; ifa.ONESHOT = 1'b0;
        push_a("zero_pat_c0", 2'b00, 1'b1, 1'b0, 2'd0); cyc();
        push_a("zero_pat_c1", 2'b00, 1'b1, 1'b0, 2'd0); cyc();
        ifa.STOP = 1'b1;
        idle_a("zero_pat_stop");

        // Load patterns
        p0 = 4'b0101; p1 = 4'b0011;
        ifa.PAT_WE = 1'b1; ifa.PAT_CH = 1'b0; ifa.PAT_DATA = p0;
        idle_a("write_ch0");
        ifa.PAT_WE = 1'b1; ifa.PAT_CH = 1'b1; ifa.PAT_DATA = p1;
        idle_a("write_ch1");

        // Loop playback for 30 cycles: steps 0..3 then wrap, never DONE
        ifa.START = 1'b1; ifa.ONESHOT = 1'b0;
        run_a("loop", 0, 29);
        ifa.STOP = 1'b1;
        idle_a("loop_stop");

        // One-shot: DONE exactly 12 cycles after START, one cycle wide
        ifa.START = 1'b1; ifa.ONESHOT = 1'b1;
        run_a("oneshot", 0, 11);
        push_a("oneshot_done", 2'b00, 1'b0, 1'b1, 2'd0); cyc();
        idle_a("oneshot_after0");
        idle_a("oneshot_after1");

        // STOP and START together at step 2: STOP wins
        ifa.START = 1'b1; ifa.ONESHOT = 1'b0;
        run_a("pre_stop", 0, 6);
        ifa.STOP = 1'b1; ifa.START = 1'b1;
        idle_a("stop_beats_start");
        idle_a("stop_after");

        // START alone at step 2 restarts from step 0 and replays everything
        ifa.START = 1'b1;
        run_a("pre_restart", 0, 6);
        ifa.START = 1'b1;
        run_a("restart", 0, 11);
        ifa.STOP = 1'b1;
        idle_a("restart_stop");

        // Live write of ch0 during step 1: visible next cycle, timing unchanged
        ifa.START = 1'b1;
        run_a("pre_live", 0, 3);
        p0 = 4'b1111;
        ifa.PAT_WE = 1'b1; ifa.PAT_CH = 1'b0; ifa.PAT_DATA = p0;
        run_a("live", 4, 14);
        ifa.STOP = 1'b1;
        idle_a("live_stop");

        // START on the final terminal cycle of a one-shot: restart, no DONE
        ifa.START = 1'b1; ifa.ONESHOT = 1'b1;
        run_a("os_pre", 0, 11);
        ifa.START = 1'b1;
        run_a("final_restart", 0, 11);
        push_a("final_restart_done", 2'b00, 1'b0, 1'b1, 2'd0); cyc();
        idle_a("final_restart_after");

        // Reset mid-run aborts without DONE and clears the pattern store
        ifa.START = 1'b1; ifa.ONESHOT = 1'b1;
        run_a("pre_reset", 0, 4);
        rst_n = 1'b0;
        idle_a("reset_abort");
        rst_n = 1'b1;
        idle_a("post_reset");
        p0 = 4'b0000; p1 = 4'b0000;
        ifa.START = 1'b1; ifa.ONESHOT = 1'b0;
        push_a("cleared_pat", 2'b00, 1'b1, 1'b0, 2'd0); cyc();
        ifa.STOP = 1'b1;
        idle_a("cleared_stop");

        // dut_b: valid write, then a write to nonexistent channel 1
        q0 = 3'b101;
        ifb.PAT_WE = 1'b1; ifb.PAT_CH = 1'b0; ifb.PAT_DATA = q0;
        push_b("b_write_ch0", 1'b0, 1'b0, 1'b0, 2'd0); cyc();
        ifb.PAT_WE = 1'b1; ifb.PAT_CH = 1'b1; ifb.PAT_DATA = 3'b010;
        push_b("b_write_bad", 1'b0, 1'b0, 1'b0, 2'd0); cyc();

        // dut_b one-shot with PRESCALE=1: steps on consecutive cycles, DONE after 3
        ifb.START = 1'b1; ifb.ONESHOT = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_b($sformatf("b_step%0d", i), q0[i], 1'b1, 1'b0, 2'(i));
            cyc();
        end
        push_b("b_done", 1'b0, 1'b0, 1'b1, 2'd0); cyc();
        push_b("b_after", 1'b0, 1'b0, 1'b0, 2'd0); cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
